// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined ALU with valid/ready streams on both sides.
//
// Sixteen operations on signed W-bit operands. Stage 1 registers the operands
// of an accepted beat. Stage 2 registers the result together with the ZERO
// and OVF status flags. OP_CNT counts the result beats taken by downstream.
//
// Handshake: a beat moves when valid and ready are both high at a rising
// edge. The source holds its data steady while valid is high and ready is
// low. IN_READY is combinational from OUT_READY, so a full pipe can accept a
// new beat in the same cycle that its oldest result leaves.
//
// Optional feature: when the macro ALU_PIPE_SAT_EN is defined, ops 0, 1 and
// 8 saturate on signed overflow instead of wrapping. OVF reports the overflow
// in both builds.
//
// Parameters
//   W          operand/result width (>= 2)
//   CNT_W      width of the completed-op counter
// Ports
//   CLK        clock; all state changes on its rising edge
//   RST_N      asynchronous active-low reset
//   IN_VALID   operand beat valid
//   IN_READY   block can accept a beat this cycle
//   A, B       signed operands
//   INST       opcode (0..F)
//   SEL        select bit for ops 6, 7 and F
//   OUT_VALID  result beat valid
//   OUT_READY  downstream accepts the result
//   Z          result
//   ZERO       Z == 0
//   OVF        signed overflow (ops 0, 1 and 8 only; 0 for all other ops)
//   OP_CNT     number of result beats consumed; wraps silently
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [3:0]       INST,
    input  logic             SEL,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [W-1:0]     Z,
    output logic             ZERO,
    output logic             OVF,
    output logic [CNT_W-1:0] OP_CNT
);

    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
`ifdef ALU_PIPE_SAT_EN
    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
`endif

    logic         s1_v;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic [3:0]   s1_inst;
    logic         s1_sel;

    logic         s1_en;
    logic         s2_en;

    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic [W-1:0] neg;
    logic         a_s;
    logic         b_s;
    logic         ovf_add;
    logic         ovf_sub;
    logic         ovf_neg;
    logic         lt;
    logic         eq;
    logic [W-1:0] alu_z;
    logic         alu_ovf;

    // Stage 2 can load when it is empty or its beat is leaving this cycle.
    // Stage 1 can load when it is empty or its beat is moving into stage 2.
    assign s2_en    = !OUT_VALID || OUT_READY;
    assign s1_en    = !s1_v || s2_en;
    assign IN_READY = s1_en;

    assign sum  = s1_a + s1_b;
    assign diff = s1_a - s1_b;
    assign neg  = '0 - s1_a;
    assign a_s  = s1_a[W-1];
    assign b_s  = s1_b[W-1];

    // Signed overflow: operands of equal sign give a sum of the other sign;
    // operands of differing sign give a difference whose sign is not A's;
    // negating the most-negative value cannot be represented.
    assign ovf_add = (a_s == b_s) && (sum[W-1] != a_s);
    assign ovf_sub = (a_s != b_s) && (diff[W-1] != a_s);
    assign ovf_neg = (s1_a == MIN_VAL);

    assign lt = $signed(s1_a) < $signed(s1_b);
    assign eq = (s1_a == s1_b);

    always_comb begin
        alu_z   = '0;
        alu_ovf = 1'b0;
        case (s1_inst)
            4'h0: begin
                alu_z   = sum;
                alu_ovf = ovf_add;
`ifdef ALU_PIPE_SAT_EN
                // Overflowing sum takes the sign of both operands.
                if (ovf_add) alu_z = a_s ? MIN_VAL : MAX_VAL;
`endif
            end
            4'h1: begin
                alu_z   = neg;
                alu_ovf = ovf_neg;
`ifdef ALU_PIPE_SAT_EN
                if (ovf_neg) alu_z = MAX_VAL;
`endif
            end
            4'h2: alu_z = s1_a & s1_b;
            4'h3: alu_z = s1_a | s1_b;
            4'h4: alu_z = s1_a ^ s1_b;
            4'h5: alu_z = ~s1_a;
            4'h6: alu_z = s1_sel ? s1_b : s1_a;
            4'h7: alu_z = s1_sel ? s1_a : s1_b;
            4'h8: begin
                alu_z   = diff;
                alu_ovf = ovf_sub;
`ifdef ALU_PIPE_SAT_EN
                // Overflowing difference goes toward A's sign.
                if (ovf_sub) alu_z = a_s ? MIN_VAL : MAX_VAL;
`endif
            end
            4'h9: alu_z = {{(W-1){1'b0}}, lt};
            4'hA: alu_z = {{(W-1){1'b0}}, lt || eq};
            4'hB: alu_z = {{(W-1){1'b0}}, !(lt || eq)};
            4'hC: alu_z = {{(W-1){1'b0}}, !lt};
            4'hD: alu_z = {{(W-1){1'b0}}, eq};
            4'hE: alu_z = {{(W-1){1'b0}}, !eq};
            4'hF: alu_z = {{(W-1){1'b0}}, s1_sel ^ s1_b[0]};
            // Reached only by an opcode with X/Z bits; makes that visible in sim.
            default: alu_z = 'x;
        endcase
    end

    // Stage 1: operand registers. They change only on an accepted beat.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_v    <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_inst <= '0;
            s1_sel  <= 1'b0;
        end else if (s1_en) begin
            s1_v <= IN_VALID;
            if (IN_VALID) begin
                s1_a    <= A;
                s1_b    <= B;
                s1_inst <= INST;
                s1_sel  <= SEL;
            end
        end
    end

    // Stage 2: result registers. They hold while stalled or when stage 2 empties.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_VALID <= 1'b0;
            Z         <= '0;
            ZERO      <= 1'b0;
            OVF       <= 1'b0;
        end else if (s2_en) begin
            OUT_VALID <= s1_v;
            if (s1_v) begin
                Z    <= alu_z;
                ZERO <= (alu_z == '0);
                OVF  <= alu_ovf;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OP_CNT <= '0;
        end else if (OUT_VALID && OUT_READY) begin
            OP_CNT <= OP_CNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: one W=32 instance and one W=8 instance sharing
// stimulus. A scoreboard queue per instance holds the expected result
// {z, zero, ovf} of every accepted beat and is popped when a result is consumed.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  inst;
    logic        sel;

    logic        in_ready32, out_valid32, zero32, ovf32;
    logic [31:0] z32;
    logic [15:0] cnt32;
    logic        in_ready8, out_valid8, zero8, ovf8;
    logic [7:0]  z8;
    logic [15:0] cnt8;

    int errors = 0;
    int checks = 0;

    logic [33:0] exp32_q[$];
    logic [33:0] exp8_q[$];
    logic [15:0] cnt_model32 = '0;
    logic [15:0] cnt_model8  = '0;

    always #5 clk = ~clk;

    alu_pipe #(.W(32), .CNT_W(16)) dut32 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready32),
        .A(a), .B(b), .INST(inst), .SEL(sel),
        .OUT_VALID(out_valid32), .OUT_READY(out_ready),
        .Z(z32), .ZERO(zero32), .OVF(ovf32), .OP_CNT(cnt32)
    );

    alu_pipe #(.W(8), .CNT_W(16)) dut8 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready8),
        .A(a[7:0]), .B(b[7:0]), .INST(inst), .SEL(sel),
        .OUT_VALID(out_valid8), .OUT_READY(out_ready),
        .Z(z8), .ZERO(zero8), .OVF(ovf8), .OP_CNT(cnt8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: operands sign-extended to 64 bits, the exact
    // mathematical result is range-checked for overflow, then reduced to w bits.
    function automatic logic [33:0] model(input int w, input logic [31:0] ma,
                                          input logic [31:0] mb, input logic [3:0] mi,
                                          input logic ms);
        longint mask, sa, sb, r, maxv, minv;
        logic   arith, ovf;
        logic [31:0] zr;
        mask = (longint'(1) << w) - 1;
        sa = longint'(ma) & mask;
        sb = longint'(mb) & mask;
        if (ma[w-1]) sa = sa - (longint'(1) << w);
        if (mb[w-1]) sb = sb - (longint'(1) << w);
        maxv  = (longint'(1) << (w - 1)) - 1;
        minv  = -(longint'(1) << (w - 1));
        arith = 1'b0;
        ovf   = 1'b0;
        case (mi)
            4'h0: begin r = sa + sb; arith = 1'b1; end
            4'h1: begin r = -sa;     arith = 1'b1; end
            4'h2: r = longint'(ma & mb);
            4'h3: r = longint'(ma | mb);
            4'h4: r = longint'(ma ^ mb);
            4'h5: r = longint'(~ma);
            4'h6: r = ms ? longint'(mb) : longint'(ma);
            4'h7: r = ms ? longint'(ma) : longint'(mb);
            4'h8: begin r = sa - sb; arith = 1'b1; end
            4'h9: r = (sa <  sb) ? 1 : 0;
            4'hA: r = (sa <= sb) ? 1 : 0;
            4'hB: r = (sa >  sb) ? 1 : 0;
            4'hC: r = (sa >= sb) ? 1 : 0;
            4'hD: r = (sa == sb) ? 1 : 0;
            4'hE: r = (sa != sb) ? 1 : 0;
            default: r = longint'(ms ^ mb[0]);
        endcase
        if (arith) begin
            ovf = (r > maxv) || (r < minv);
`ifdef ALU_PIPE_SAT_EN
            if (r > maxv) r = maxv;
            else if (r < minv) r = minv;
`endif
        end
        r  = r & mask;
        zr = r[31:0];
        return {zr, (zr == 32'd0), ovf};
    endfunction

    // Monitor at the falling edge: inputs are stable, so this sees exactly
    // what transfers at the next rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("op_cnt32", 64'(cnt32), 64'(cnt_model32));
            check("op_cnt8", 64'(cnt8), 64'(cnt_model8));
            if (in_valid && in_ready32) exp32_q.push_back(model(32, a, b, inst, sel));
            if (in_valid && in_ready8)  exp8_q.push_back(model(8, a, b, inst, sel));
            if (out_valid32 && out_ready) begin
                check("sb32_has_entry", 64'(exp32_q.size() != 0), 64'(1'b1));
                if (exp32_q.size() != 0)
                    check("sb32_result", 64'({z32, zero32, ovf32}), 64'(exp32_q.pop_front()));
                cnt_model32 = cnt_model32 + 16'd1;
            end
            if (out_valid8 && out_ready) begin
                check("sb8_has_entry", 64'(exp8_q.size() != 0), 64'(1'b1));
                if (exp8_q.size() != 0)
                    check("sb8_result", 64'({24'h0, z8, zero8, ovf8}), 64'(exp8_q.pop_front()));
                cnt_model8 = cnt_model8 + 16'd1;
            end
        end
    end

    task automatic enter_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        exp32_q.delete();
        exp8_q.delete();
        cnt_model32 = '0;
        cnt_model8  = '0;
    endtask

    task automatic do_reset();
        enter_reset();
        tick(2);
        rst_n = 1'b1;
    endtask

    // Offers one beat with OUT_READY high and waits (bounded) for its result.
    task automatic send_one(input logic [31:0] ta, input logic [31:0] tb_v,
                            input logic [3:0] ti, input logic ts);
        a = ta; b = tb_v; inst = ti; sel = ts; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        for (int k = 0; k < 4 && out_valid32 !== 1'b1; k++) tick(1);
        check("resp_wait", 64'(out_valid32), 64'(1'b1));
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_007F;
            5: return 32'h0000_0080;
            6: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] b2b_tab [16];
    logic [31:0] exp_add_ovf;
    logic [31:0] exp_neg_min;
    int          sent;
    int          cyc;

    initial begin
        b2b_tab = '{32'h1, 32'h2, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h1, 32'h3, 32'hFFFFFFFE,
                    32'hFFFFFFFB, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0};
`ifdef ALU_PIPE_SAT_EN
        exp_add_ovf = 32'h7FFF_FFFF;
        exp_neg_min = 32'h7FFF_FFFF;
`else
        exp_add_ovf = 32'h8000_0000;
        exp_neg_min = 32'h8000_0000;
`endif
        a = '0; b = '0; inst = '0; sel = 1'b0; out_ready = 1'b1;
        enter_reset();

        // Reset state
        tick(2);
        check("rst_out_valid", 64'(out_valid32), 64'(1'b0));
        check("rst_z", 64'(z32), 64'(0));
        check("rst_zero", 64'(zero32), 64'(1'b0));
        check("rst_ovf", 64'(ovf32), 64'(1'b0));
        check("rst_op_cnt", 64'(cnt32), 64'(0));
        check("rst_in_ready", 64'(in_ready32), 64'(1'b1));
        rst_n = 1'b1;
        check("post_rst_in_ready", 64'(in_ready32), 64'(1'b1));

        // ADD overflow and two-edge latency
        a = 32'h7FFF_FFFF; b = 32'h1; inst = 4'h0; sel = 1'b0; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        check("add_lat_not_yet", 64'(out_valid32), 64'(1'b0));
        tick(1);
        check("add_lat_valid", 64'(out_valid32), 64'(1'b1));
        check("add_ovf_z", 64'(z32), 64'(exp_add_ovf));
        check("add_ovf_flag", 64'(ovf32), 64'(1'b1));

        // All 16 ops back to back, one beat per cycle
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                a = 32'hFFFF_FFFE; b = 32'h3; sel = 1'b1; inst = i[3:0]; in_valid = 1'b1;
                check("b2b_in_ready", 64'(in_ready32), 64'(1'b1));
            end else begin
                in_valid = 1'b0;
            end
            tick(1);
            if (i >= 1) begin
                check("b2b_valid", 64'(out_valid32), 64'(1'b1));
                check("b2b_z", 64'(z32), 64'(b2b_tab[i-1]));
            end
        end

        // NEG of most-negative; SUB 0-0
        send_one(32'h8000_0000, 32'h0, 4'h1, 1'b0);
        check("neg_min_z", 64'(z32), 64'(exp_neg_min));
        check("neg_min_ovf", 64'(ovf32), 64'(1'b1));
        send_one(32'h0, 32'h0, 4'h8, 1'b0);
        check("sub_zero_z", 64'(z32), 64'(0));
        check("sub_zero_flag", 64'(zero32), 64'(1'b1));
        check("sub_zero_ovf", 64'(ovf32), 64'(1'b0));

        // Backpressure: OUT_READY low for 5 edges with 3 beats offered
        do_reset();
        out_ready = 1'b0;
        a = 32'd10;  b = 32'd20;      inst = 4'h0; in_valid = 1'b1;
        tick(1);
        a = 32'd100; b = 32'd1;       inst = 4'h8;
        tick(1);
        a = 32'hF0F0; b = 32'hFF00;   inst = 4'h2;
        tick(1);
        check("stall_in_ready", 64'(in_ready32), 64'(1'b0));
        check("stall_valid", 64'(out_valid32), 64'(1'b1));
        check("stall_z_a", 64'(z32), 64'(30));
        tick(1);
        check("stall_z_b", 64'(z32), 64'(30));
        tick(1);
        check("stall_z_c", 64'(z32), 64'(30));
        check("stall_in_ready_c", 64'(in_ready32), 64'(1'b0));
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready32), 64'(1'b1));
        tick(1);
        in_valid = 1'b0;
        check("drain_z1", 64'(z32), 64'(99));
        tick(1);
        check("drain_z2", 64'(z32), 64'(32'hF000));
        check("drain_valid2", 64'(out_valid32), 64'(1'b1));
        tick(1);
        check("drain_empty", 64'(out_valid32), 64'(1'b0));
        check("stall_op_cnt", 64'(cnt32), 64'(3));

        // Reset asserted mid-stall
        out_ready = 1'b0;
        a = 32'd1; b = 32'd2; inst = 4'h0; in_valid = 1'b1;
        tick(1);
        a = 32'd3; b = 32'd4;
        tick(1);
        in_valid = 1'b0;
        tick(1);
        check("pre_rst_valid", 64'(out_valid32), 64'(1'b1));
        enter_reset();
        #1;
        check("midrst_valid", 64'(out_valid32), 64'(1'b0));
        check("midrst_op_cnt", 64'(cnt32), 64'(0));
        check("midrst_z", 64'(z32), 64'(0));
        check("midrst_in_ready", 64'(in_ready32), 64'(1'b1));
        tick(2);
        rst_n = 1'b1;
        check("midrst_rel_in_ready", 64'(in_ready32), 64'(1'b1));
        out_ready = 1'b1;
        send_one(32'd5, 32'd6, 4'h0, 1'b0);
        check("midrst_first_z", 64'(z32), 64'(11));

        // Random traffic: 1024 beats, random IN_VALID / OUT_READY
        tick(1);
        do_reset();
        sent = 0;
        cyc  = 0;
        while (sent < 1024 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a    = rnd_operand();
            b    = rnd_operand();
            inst = 4'($urandom_range(0, 15));
            sel  = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready32) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rand_all_sent", 64'(sent), 64'(1024));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && (exp32_q.size() != 0 || exp8_q.size() != 0); k++) tick(1);
        tick(1);
        check("rand_q32_empty", 64'(exp32_q.size()), 64'(0));
        check("rand_q8_empty", 64'(exp8_q.size()), 64'(0));
        check("rand_op_cnt32", 64'(cnt32), 64'(1024));
        check("rand_op_cnt8", 64'(cnt8), 64'(1024));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
